// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two memory masters, the port arbiter and the single-port memory.
// The slave view belongs to the arbiter; the master view is the masters-plus-memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  logic              busy;
  logic              owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_address, mem_read_enable, mem_write_enable, mem_data_in,
    input  mem_data_out,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_address, mem_read_enable, mem_write_enable, mem_data_in,
    output mem_data_out,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port memory: one transaction at a time, read-latency wait,
// one-cycle ack to the owning port. Round-robin or fixed priority on contention.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int RR_MODE      = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              any_req;
  logic              grant;

  // On a tie, round-robin hands the slot to the port that did not win last time.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      grant = (RR_MODE != 0) ? ~last_q : 1'b0;
    end else begin
      grant = bus.m1_req;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant;
          last_d  = grant;
          we_d    = grant ? bus.m1_we    : bus.m0_we;
          addr_d  = grant ? bus.m1_addr  : bus.m0_addr;
          wdata_d = grant ? bus.m1_wdata : bus.m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = 3'(READ_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (owner_q) rdata1_d = bus.mem_data_out;
          else         rdata0_d = bus.mem_data_out;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 3'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Latched command only reaches the memory pins in ISSUE, so it carries no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.mem_address      = (state_q == ISSUE) ? addr_q : '0;
  assign bus.mem_read_enable  = (state_q == ISSUE) && !we_q;
  assign bus.mem_write_enable = (state_q == ISSUE) && we_q;
  assign bus.mem_data_in      = ((state_q == ISSUE) && we_q) ? wdata_q : '0;
  assign bus.m0_ack           = (state_q == DONE) && !owner_q;
  assign bus.m1_ack           = (state_q == DONE) && owner_q;
  assign bus.m0_rdata         = rdata0_q;
  assign bus.m1_rdata         = rdata1_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.owner            = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (L=1 round-robin, L=3 fixed priority) with a
// latency-accurate memory model and a transaction-level reference of memory and rdata.
module tb_mem_port_arbiter;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct {
    int          port;
    int          cyc;
    logic        both;
    logic        stray;
    logic [15:0] rdata;
    logic [15:0] odata;
    int          nre;
    int          nwr;
    logic [15:0] iaddr;
    logic [15:0] idin;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  logic        t_req   [2][2];
  logic        t_we    [2][2];
  logic [15:0] t_addr  [2][2];
  logic [15:0] t_wdata [2][2];
  logic        o_ack   [2][2];
  logic [15:0] o_rdata [2][2];
  logic        o_re    [2];
  logic        o_wr    [2];
  logic [15:0] o_addr  [2];
  logic [15:0] o_din   [2];
  logic        o_busy  [2];
  logic        o_owner [2];

  cmd_t        cmds [2][8];
  int          ncmd [2];
  ev_t         evs[$];
  logic [15:0] ref_mem [2][256];
  logic [15:0] exp_rd  [2][2];

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(1), .RR_MODE(1)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(3), .RR_MODE(0)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  assign ifa.m0_req = t_req[0][0];   assign ifa.m0_we = t_we[0][0];
  assign ifa.m0_addr = t_addr[0][0]; assign ifa.m0_wdata = t_wdata[0][0];
  assign ifa.m1_req = t_req[0][1];   assign ifa.m1_we = t_we[0][1];
  assign ifa.m1_addr = t_addr[0][1]; assign ifa.m1_wdata = t_wdata[0][1];
  assign ifb.m0_req = t_req[1][0];   assign ifb.m0_we = t_we[1][0];
  assign ifb.m0_addr = t_addr[1][0]; assign ifb.m0_wdata = t_wdata[1][0];
  assign ifb.m1_req = t_req[1][1];   assign ifb.m1_we = t_we[1][1];
  assign ifb.m1_addr = t_addr[1][1]; assign ifb.m1_wdata = t_wdata[1][1];

  assign o_ack[0][0] = ifa.m0_ack;     assign o_ack[0][1] = ifa.m1_ack;
  assign o_rdata[0][0] = ifa.m0_rdata; assign o_rdata[0][1] = ifa.m1_rdata;
  assign o_ack[1][0] = ifb.m0_ack;     assign o_ack[1][1] = ifb.m1_ack;
  assign o_rdata[1][0] = ifb.m0_rdata; assign o_rdata[1][1] = ifb.m1_rdata;
  assign o_re[0] = ifa.mem_read_enable;  assign o_re[1] = ifb.mem_read_enable;
  assign o_wr[0] = ifa.mem_write_enable; assign o_wr[1] = ifb.mem_write_enable;
  assign o_addr[0] = ifa.mem_address;    assign o_addr[1] = ifb.mem_address;
  assign o_din[0] = ifa.mem_data_in;     assign o_din[1] = ifb.mem_data_in;
  assign o_busy[0] = ifa.busy;           assign o_busy[1] = ifb.busy;
  assign o_owner[0] = ifa.owner;         assign o_owner[1] = ifb.owner;

  function automatic logic [15:0] init_val(input int i);
    if (i == 'h10) return 16'hBEEF;
    return 16'((i * 40503) ^ 'h5A5A);
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic cmd_t mk(input logic we, input logic [15:0] a, input logic [15:0] w);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = w;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
  endfunction

  // Memory model: data appears exactly L cycles after the read strobe, random junk otherwise.
  logic [7:0]  pv [2];
  logic [15:0] pd [2][8];
  logic [15:0] env_mem [2][256];
  logic [15:0] junk;
  always @(posedge clk) begin
    junk <= 16'($urandom);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        pv[d] <= '0;
        for (int i = 0; i < 256; i++) env_mem[d][i] <= init_val(i);
      end else begin
        if (o_wr[d]) env_mem[d][o_addr[d][7:0]] <= o_din[d];
        pv[d] <= {pv[d][6:0], o_re[d]};
      end
      pd[d][0] <= env_mem[d][o_addr[d][7:0]];
      for (int i = 1; i < 8; i++) pd[d][i] <= pd[d][i-1];
    end
  end
  assign ifa.mem_data_out = pv[0][0] ? pd[0][0] : junk;
  assign ifb.mem_data_out = pv[1][2] ? pd[1][2] : junk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ref_init(input int d);
    for (int i = 0; i < 256; i++) ref_mem[d][i] = init_val(i);
    exp_rd[d][0] = '0;
    exp_rd[d][1] = '0;
  endtask

  task automatic set_cmd(input int d, input int p, input cmd_t c);
    t_req[d][p] = 1'b1; t_we[d][p] = c.we; t_addr[d][p] = c.addr; t_wdata[d][p] = c.wdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) t_req[d][p] = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    ref_init(0);
    ref_init(1);
  endtask

  // Master behaviour: each port works through cmds[p], keeping req up through the ack cycle and
  // presenting its next command (or dropping req) just after that cycle ends. Records every ack.
  task automatic run_engine(input int d, input int budget, output int tmo);
    int pi [2];
    int nre, nwr, upd;
    logic [15:0] ia, idn;
    ev_t e;
    pi[0] = 0; pi[1] = 0; nre = 0; nwr = 0; upd = -1; ia = '0; idn = '0; tmo = 1;
    evs.delete();
    for (int p = 0; p < 2; p++) begin
      if (ncmd[p] > 0) set_cmd(d, p, cmds[p][0]);
      else t_req[d][p] = 1'b0;
    end
    for (int k = 0; k < budget; k++) begin
      tick();
      if (upd >= 0) begin
        if (pi[upd] < ncmd[upd]) set_cmd(d, upd, cmds[upd][pi[upd]]);
        else t_req[d][upd] = 1'b0;
        upd = -1;
      end
      if (o_re[d]) begin nre++; ia = o_addr[d]; end
      if (o_wr[d]) begin nwr++; ia = o_addr[d]; idn = o_din[d]; end
      if (o_ack[d][0] || o_ack[d][1]) begin
        e.port  = o_ack[d][1] ? 1 : 0;
        e.both  = o_ack[d][0] && o_ack[d][1];
        e.cyc   = cyc;
        e.rdata = o_rdata[d][e.port];
        e.odata = o_rdata[d][1 - e.port];
        e.nre = nre; e.nwr = nwr; e.iaddr = ia; e.idin = idn;
        e.stray = (pi[e.port] >= ncmd[e.port]);
        evs.push_back(e);
        nre = 0; nwr = 0;
        if (!e.stray) pi[e.port]++;
        upd = e.port;
      end
      if (upd < 0 && pi[0] >= ncmd[0] && pi[1] >= ncmd[1] && !o_busy[d]) begin
        tmo = 0;
        break;
      end
    end
    for (int p = 0; p < 2; p++) t_req[d][p] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({o_ack[d][0], o_ack[d][1], o_rdata[d][0], o_rdata[d][1], o_re[d], o_wr[d],
           o_addr[d], o_din[d], o_busy[d], o_owner[d]} !== '0) begin
        n_err++;
        $display("FAIL reset_state dut%0d: ack=%b%b rd0=%h rd1=%h re=%b we=%b addr=%h din=%h busy=%b owner=%b, required all 0",
                 d, o_ack[d][0], o_ack[d][1], o_rdata[d][0], o_rdata[d][1], o_re[d], o_wr[d],
                 o_addr[d], o_din[d], o_busy[d], o_owner[d]);
      end
    end
    reset = 1'b0;
    ref_init(0);
    ref_init(1);
  endtask

  // Directed single transactions first, then random ones with random idle gaps (including none).
  task automatic test_single_txns();
    cmd_t c;
    int d, p, t0, tmo, want_lat;
    logic [15:0] want;
    for (int i = 0; i < 30; i++) begin
      case (i)
        0: begin d = 0; p = 0; c = mk(1'b0, 16'h0010, 16'h0000); end
        1: begin d = 0; p = 1; c = mk(1'b1, 16'h0020, 16'h1234); end
        2: begin d = 0; p = 1; c = mk(1'b0, 16'h0020, 16'h0000); end
        3: begin d = 1; p = 1; c = mk(1'b0, 16'h00FF, 16'h0000); end
        default: begin
          d = $urandom_range(0, 1);
          p = $urandom_range(0, 1);
          c = rand_cmd();
          repeat ($urandom_range(0, 2)) tick();
        end
      endcase
      ncmd[0] = 0; ncmd[1] = 0;
      cmds[p][0] = c; ncmd[p] = 1;
      t0 = cyc;
      run_engine(d, 40, tmo);
      n_vec++;
      if (tmo != 0 || evs.size() != 1) begin
        n_err++;
        $display("FAIL txn%0d completion: timeout=%0d acks=%0d, required 0/1", i, tmo, evs.size());
      end else begin
        n_vec++;
        if (evs[0].port != p || evs[0].both || evs[0].stray || o_owner[d] !== 1'(p)) begin
          n_err++;
          $display("FAIL txn%0d ack_owner: port=%0d both=%b stray=%b owner=%b, required port/owner %0d",
                   i, evs[0].port, evs[0].both, evs[0].stray, o_owner[d], p);
        end
        want_lat = c.we ? 2 : 2 + lat_of(d);
        n_vec++;
        if (evs[0].cyc - t0 != want_lat) begin
          n_err++;
          $display("FAIL txn%0d ack_latency: got %0d required %0d", i, evs[0].cyc - t0, want_lat);
        end
        n_vec++;
        if (evs[0].nre != (c.we ? 0 : 1) || evs[0].nwr != (c.we ? 1 : 0) || evs[0].iaddr !== c.addr ||
            (c.we && evs[0].idin !== c.wdata)) begin
          n_err++;
          $display("FAIL txn%0d mem_strobe: re_cycles=%0d we_cycles=%0d addr=%h din=%h, required we=%b addr=%h din=%h",
                   i, evs[0].nre, evs[0].nwr, evs[0].iaddr, evs[0].idin, c.we, c.addr, c.wdata);
        end
        want = c.we ? exp_rd[d][p] : ref_mem[d][c.addr[7:0]];
        n_vec++;
        if (evs[0].rdata !== want) begin
          n_err++;
          $display("FAIL txn%0d rdata: got %h required %h", i, evs[0].rdata, want);
        end
        n_vec++;
        if (evs[0].odata !== exp_rd[d][1-p]) begin
          n_err++;
          $display("FAIL txn%0d other_rdata: got %h required %h", i, evs[0].odata, exp_rd[d][1-p]);
        end
      end
      if (c.we) ref_mem[d][c.addr[7:0]] = c.wdata;
      else exp_rd[d][p] = ref_mem[d][c.addr[7:0]];
    end
  endtask

  // Both ports keep a request pending until their command lists run out.
  task automatic test_contention(input int d);
    int tmo, t0, want_port, last, idx, base, want_lat, ntot;
    int rem [2];
    cmd_t c;
    logic [15:0] want;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      ncmd[p] = $urandom_range(2, 5);
      for (int j = 0; j < ncmd[p]; j++) cmds[p][j] = rand_cmd();
    end
    ntot = ncmd[0] + ncmd[1];
    t0 = cyc;
    run_engine(d, 300, tmo);
    n_vec++;
    if (tmo != 0 || evs.size() != ntot) begin
      n_err++;
      $display("FAIL contend dut%0d completion: timeout=%0d acks=%0d, required 0/%0d", d, tmo, evs.size(), ntot);
    end
    rem[0] = ncmd[0]; rem[1] = ncmd[1]; last = 1;
    for (int i = 0; i < evs.size() && i < ntot; i++) begin
      if (rem[0] > 0 && rem[1] > 0) want_port = (d == 0) ? 1 - last : 0;
      else want_port = (rem[0] > 0) ? 0 : 1;
      last = want_port;
      idx = ncmd[want_port] - rem[want_port];
      rem[want_port]--;
      c = cmds[want_port][idx];
      n_vec++;
      if (evs[i].port != want_port || evs[i].both || evs[i].stray) begin
        n_err++;
        $display("FAIL contend dut%0d order[%0d]: port=%0d both=%b stray=%b, required port %0d",
                 d, i, evs[i].port, evs[i].both, evs[i].stray, want_port);
      end
      base = (i == 0) ? t0 : evs[i-1].cyc + 1;
      want_lat = c.we ? 2 : 2 + lat_of(d);
      n_vec++;
      if (evs[i].cyc - base != want_lat) begin
        n_err++;
        $display("FAIL contend dut%0d latency[%0d]: got %0d required %0d", d, i, evs[i].cyc - base, want_lat);
      end
      n_vec++;
      if (evs[i].nre != (c.we ? 0 : 1) || evs[i].nwr != (c.we ? 1 : 0) || evs[i].iaddr !== c.addr ||
          (c.we && evs[i].idin !== c.wdata)) begin
        n_err++;
        $display("FAIL contend dut%0d strobe[%0d]: re=%0d we=%0d addr=%h din=%h, required we=%b addr=%h din=%h",
                 d, i, evs[i].nre, evs[i].nwr, evs[i].iaddr, evs[i].idin, c.we, c.addr, c.wdata);
      end
      want = c.we ? exp_rd[d][want_port] : ref_mem[d][c.addr[7:0]];
      n_vec++;
      if (evs[i].rdata !== want || evs[i].odata !== exp_rd[d][1-want_port]) begin
        n_err++;
        $display("FAIL contend dut%0d rdata[%0d]: owner %h other %h, required %h / %h",
                 d, i, evs[i].rdata, evs[i].odata, want, exp_rd[d][1-want_port]);
      end
      if (c.we) ref_mem[d][c.addr[7:0]] = c.wdata;
      else exp_rd[d][want_port] = want;
    end
  endtask

  task automatic test_reset_mid_wait();
    int acks, tmo, t0;
    do_reset();
    set_cmd(1, 1, mk(1'b0, 16'($urandom_range(0, 15)), 16'h0000));
    tick();
    tick();
    tick();
    n_vec++;
    if (o_busy[1] !== 1'b1 || o_re[1] !== 1'b0 || o_wr[1] !== 1'b0 || o_ack[1][1] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_wait pre_reset: busy=%b re=%b we=%b ack1=%b, required 1/0/0/0",
               o_busy[1], o_re[1], o_wr[1], o_ack[1][1]);
    end
    reset = 1'b1;
    t_req[1][1] = 1'b0;
    tick();
    n_vec++;
    if ({o_busy[1], o_ack[1][0], o_ack[1][1], o_re[1], o_wr[1], o_rdata[1][1]} !== '0) begin
      n_err++;
      $display("FAIL mid_wait abort: busy=%b ack=%b%b re=%b we=%b rd1=%h, required all 0",
               o_busy[1], o_ack[1][0], o_ack[1][1], o_re[1], o_wr[1], o_rdata[1][1]);
    end
    reset = 1'b0;
    ref_init(0);
    ref_init(1);
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_ack[1][0] || o_ack[1][1] || o_busy[1] || o_re[1] || o_wr[1]) acks++;
    end
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL mid_wait quiet: %0d active cycles after abort, required 0", acks);
    end
    ncmd[0] = 1; ncmd[1] = 0;
    cmds[0][0] = mk(1'b0, 16'h0010, 16'h0000);
    t0 = cyc;
    run_engine(1, 40, tmo);
    n_vec++;
    if (tmo != 0 || evs.size() != 1) begin
      n_err++;
      $display("FAIL mid_wait fresh_done: timeout=%0d acks=%0d, required 0/1", tmo, evs.size());
    end else begin
      n_vec++;
      if (evs[0].port != 0 || evs[0].cyc - t0 != 5 || evs[0].rdata !== 16'hBEEF) begin
        n_err++;
        $display("FAIL mid_wait fresh_read: port=%0d latency=%0d rdata=%h, required 0/5/beef",
                 evs[0].port, evs[0].cyc - t0, evs[0].rdata);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        t_req[d][p] = 1'b0; t_we[d][p] = 1'b0; t_addr[d][p] = '0; t_wdata[d][p] = '0;
      end
    end
    test_reset();
    test_single_txns();
    test_contention(0);
    test_contention(1);
    test_contention(0);
    test_contention(1);
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
